// File: rtl/nand_page_read_capture.sv
// NAND page read capture: waits out tWB and the R/B# busy/ready handshake, then
// strobes RE# once per byte and streams captured IO bytes on a valid/ready port.
module nand_page_read_capture #(
  parameter int PAGE_BYTES   = 2048,
  parameter int RE_LOW_CYC   = 2,
  parameter int RE_HIGH_CYC  = 2,
  parameter int TWB_CYC      = 4,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] len,
  input  logic        rb_n,
  input  logic [7:0]  io_in,
  output logic        re_n,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  // Stream handshake: a byte transfers on every clk edge where data_valid and
  // data_ready are both 1; data_out/data_valid hold steady until that edge.

  localparam int CW = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WB,
    S_WAIT_RDY,
    S_RE_LOW,
    S_RE_HIGH,
    S_FINISH
  } state_t;

  state_t        state;
  logic          rb_q1;
  logic          rb_s;
  logic          seen_low;
  logic [CW-1:0] cnt;
  logic [11:0]   remaining;
  logic [11:0]   len_clamped;

  assign len_clamped = (len > 12'(PAGE_BYTES)) ? 12'(PAGE_BYTES) : len;

  // R/B# is driven by the device with no relation to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_q1 <= 1'b1;
      rb_s  <= 1'b1;
    end else begin
      rb_q1 <= rb_n;
      rb_s  <= rb_q1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      re_n        <= 1'b1;
      data_out    <= 8'd0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      seen_low    <= 1'b0;
      cnt         <= '0;
      remaining   <= 12'd0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          // A start coinciding with the previous read's done pulse is dropped.
          if (start && !done) begin
            remaining <= len_clamped;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= S_WAIT_WB;
          end
        end

        S_WAIT_WB: begin
          if (cnt == CW'(TWB_CYC - 1)) begin
            cnt      <= '0;
            seen_low <= 1'b0;
            state    <= S_WAIT_RDY;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end

        S_WAIT_RDY: begin
          if (!rb_s) seen_low <= 1'b1;
          // Ready means a low-then-high sequence seen from inside this state.
          if (seen_low && rb_s) begin
            cnt <= '0;
            if (remaining == 12'd0) begin
              state <= S_FINISH;
            end else begin
              re_n  <= 1'b0;
              state <= S_RE_LOW;
            end
          end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
            done        <= 1'b1;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end

        S_RE_LOW: begin
          if (cnt == CW'(RE_LOW_CYC - 1)) begin
            re_n       <= 1'b1;
            data_out   <= io_in;
            data_valid <= 1'b1;
            remaining  <= remaining - 12'd1;
            cnt        <= '0;
            state      <= S_RE_HIGH;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end

        S_RE_HIGH: begin
          if (cnt != CW'(RE_HIGH_CYC - 1)) cnt <= cnt + 17'd1;
          // Backpressure simply stretches RE# high until the byte is taken.
          if (cnt == CW'(RE_HIGH_CYC - 1) && (!data_valid || data_ready)) begin
            cnt <= '0;
            if (remaining == 12'd0) begin
              state <= S_FINISH;
            end else begin
              re_n  <= 1'b0;
              state <= S_RE_LOW;
            end
          end
        end

        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nand_page_read_capture.md
Name: nand_page_read_capture

Overview:
- Downstream of the NAND address/command latch stage. Started once the 0x30 read-confirm command has been written.
- Waits out tWB, then waits for the device to go busy and return ready on R/B#.
- Strobes RE# once per byte to capture page data from the 8-bit IO bus.
- Presents each byte on a valid/ready stream to the page buffer. Owns RE# only; CE#/CLE/ALE/WE# stay with the upstream stage.

Parameters:
- PAGE_BYTES, 2048, maximum bytes per read; longer requests are clamped to this.
- RE_LOW_CYC, 2, clk cycles RE# is held low per byte (tRP), minimum 1.
- RE_HIGH_CYC, 2, minimum clk cycles RE# is held high between bytes (tREH), minimum 1.
- TWB_CYC, 4, clk cycles after start during which R/B# is ignored (tWB).
- BUSY_TIMEOUT, 65535, maximum cycles spent in WAIT_RDY before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin a read. Ignored while busy=1.
- len  in  12  bytes to read, latched on start. 0 = no RE# strobes. Values > PAGE_BYTES are clamped.
- rb_n  in  1  NAND R/B# (0 = busy); asynchronous, double-flop synchronised internally
- io_in  in  8  NAND IO bus, read direction
- re_n  out  1  NAND RE#
- data_out  out  8  captured byte
- data_valid  out  1  data_out is valid
- data_ready  in  1  consumer accepts data_out when data_valid and data_ready are both 1
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses
- done  out  1  one-cycle pulse at end of read, normal or aborted
- timeout_err  out  1  one-cycle pulse, coincident with done, when the read is aborted by timeout

Behaviour:
- Reset values (asynchronous): re_n=1, data_out=0, data_valid=0, busy=0, done=0, timeout_err=0, state=IDLE, all counters 0. Synchroniser flops reset to 1.
- Reset mid-read: re_n returns high immediately. Any pending byte is discarded. No done pulse is generated.
- rb_s is the synchronised rb_n, 2-cycle latency.
- IDLE: start=1 latches min(len, PAGE_BYTES) into remaining, sets busy, goes to WAIT_WB.
- WAIT_WB: counts TWB_CYC cycles ignoring rb_s, then goes to WAIT_RDY. Timeout counter clears on entry.
- WAIT_RDY: device ready is defined as rb_s=1 observed after rb_s=0 has been seen at least once in this state.
  - If rb_s never goes low, the state waits for the low-then-high sequence; it does not exit early.
  - Timeout counter increments each cycle. On reaching BUSY_TIMEOUT: done=1, timeout_err=1, busy=0, go to IDLE.
  - On ready: if remaining=0, go to FINISH; else go to RE_LOW.
- RE_LOW: re_n=0 for exactly RE_LOW_CYC cycles. On the edge that ends the final low cycle:
  - re_n<=1, data_out<=io_in, data_valid<=1, remaining decrements.
  - Go to RE_HIGH.
- RE_HIGH: re_n=1.
  - data_valid drops on the edge after a cycle where data_valid & data_ready.
  - Leave only when at least RE_HIGH_CYC cycles have elapsed AND the byte has been accepted, i.e. backpressure stretches RE# high time.
  - Then: remaining>0 → RE_LOW; remaining=0 → FINISH.
  - If data_ready is already 1 when data_valid rises, the byte is accepted that cycle. Exit is then governed by RE_HIGH_CYC alone.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- A start asserted in the same cycle as done is ignored. Back-to-back reads need start at least one cycle after done.
- Throughput with no backpressure: one byte per RE_LOW_CYC+RE_HIGH_CYC cycles.
- data_out holds its last value after data_valid falls.
- rb_n changes outside WAIT_RDY have no effect.

Test Plan:
- len=4, io_in driven 0xA0..0xA3 on successive RE# falls, rb_n low 10 cycles then high, data_ready=1 → four bytes A0,A1,A2,A3; each RE# low 2 cycles and high ≥2 cycles; one done pulse; timeout_err=0.
- len=3, data_ready low 5 cycles after the first data_valid → re_n held high until acceptance; no byte lost or duplicated; bytes in order.
- BUSY_TIMEOUT=20, rb_n held low forever → done and timeout_err pulse together 20 cycles after WAIT_RDY entry; zero RE# strobes; busy=0 next cycle.
- len=0 → R/B# busy/ready handshake completes; no RE# strobes; done pulse; data_valid never asserted.
- len=4000 with PAGE_BYTES=2048 → exactly 2048 strobes, then done. start re-pulsed mid-read → ignored, byte count unchanged.
- rst asserted during the 2nd RE_LOW of a len=8 read → re_n=1 asynchronously; all outputs at reset values; a subsequent start runs a clean full read.
